// File: rtl/btn_event_ctrl.sv
// Turns debounced button levels into a single valid/ready event stream:
// one event per press, then auto-repeat events while the owning button is held.
module btn_event_ctrl #(
  parameter int N_BTN    = 4,
  parameter int HOLD_CYC = 16,
  parameter int REP_CYC  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         db_in,
  input  logic                     ev_ready,
  input  logic                     drop_clr,
  output logic                     ev_valid,
  output logic [$clog2(N_BTN)-1:0] ev_id,
  output logic                     ev_repeat,
  output logic                     ev_drop,
  output logic [1:0]               dbg_state
);

  localparam int IDW  = $clog2(N_BTN);
  localparam int MAXC = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Handshake: an event transfers on any rising edge where ev_valid & ev_ready;
  // ev_id/ev_repeat never change while ev_valid=1 and ev_ready=0.

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IDW-1:0]   owner, owner_n;
  logic [N_BTN-1:0] db_q;
  logic [N_BTN-1:0] rise;
  logic [IDW-1:0]   rise_idx;
  logic             take_new;
  logic             issue;
  logic             issue_rep;
  logic [IDW-1:0]   issue_id;
  logic             discard;

  assign rise      = db_in & ~db_q;
  assign discard   = issue & ev_valid & ~ev_ready;
  assign dbg_state = state;

  always_comb begin
    rise_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = IDW'(i);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    owner_n   = owner;
    take_new  = 1'b0;
    issue     = 1'b0;
    issue_rep = 1'b0;
    issue_id  = owner;
    case (state)
      IDLE: take_new = 1'b1;
      HOLD: begin
        if (!db_in[owner]) begin
          take_new = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          issue     = 1'b1;
          issue_rep = 1'b1;
          state_n   = REPEAT;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (!db_in[owner]) begin
          take_new = 1'b1;
        end else if (cnt == REP_LAST) begin
          issue     = 1'b1;
          issue_rep = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: take_new = 1'b1;
    endcase
    // A release cycle behaves like IDLE so a new press is taken without a gap.
    if (take_new) begin
      cnt_n = '0;
      if (rise != '0) begin
        owner_n   = rise_idx;
        issue     = 1'b1;
        issue_rep = 1'b0;
        issue_id  = rise_idx;
        state_n   = HOLD;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    db_q <= db_in;
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= '0;
      ev_valid  <= 1'b0;
      ev_id     <= '0;
      ev_repeat <= 1'b0;
      ev_drop   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      owner <= owner_n;
      if (issue && (!ev_valid || ev_ready)) begin
        ev_valid  <= 1'b1;
        ev_id     <= issue_id;
        ev_repeat <= issue_rep;
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
      if (discard) begin
        ev_drop <= 1'b1;
      end else if (drop_clr) begin
        ev_drop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: press-age model checked every cycle,
// plus literal expectations for the documented timing scenarios.
module tb_btn_event_ctrl;

  localparam int N = 4;
  localparam int H = 16;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] db_in;
  logic       ev_ready;
  logic       drop_clr;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_repeat;
  logic       ev_drop;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  btn_event_ctrl #(.N_BTN(N), .HOLD_CYC(H), .REP_CYC(R)) dut (
    .clk(clk), .rst(rst), .db_in(db_in), .ev_ready(ev_ready), .drop_clr(drop_clr),
    .ev_valid(ev_valid), .ev_id(ev_id), .ev_repeat(ev_repeat), .ev_drop(ev_drop),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Model: an owner button with an age in cycles since its press event.
  logic [3:0] m_prev;
  bit         m_active;
  int         m_owner;
  int         m_age;
  logic       m_valid, m_rep, m_drop;
  logic [1:0] m_id;
  bit         started = 0;

  always @(posedge clk) begin : model
    logic [3:0] rise;
    bit         iss;
    logic       irep;
    int         iid;
    if (rst) begin
      m_prev = db_in; m_active = 0; m_owner = 0; m_age = 0;
      m_valid = 0; m_id = 0; m_rep = 0; m_drop = 0;
      started = 1;
    end else if (started) begin
      rise = db_in & ~m_prev;
      m_prev = db_in;
      iss = 0; irep = 0; iid = 0;
      if (m_active && db_in[m_owner]) begin
        m_age++;
        if (m_age == H || (m_age > H && (m_age - H) % R == 0)) begin
          iss = 1; irep = 1; iid = m_owner;
        end
      end else begin
        m_active = 0;
        if (rise != 0) begin
          for (int i = N - 1; i >= 0; i--) if (rise[i]) m_owner = i;
          m_active = 1; m_age = 0;
          iss = 1; irep = 0; iid = m_owner;
        end
      end
      if (iss && !(m_valid && !ev_ready)) begin
        m_valid = 1; m_id = iid[1:0]; m_rep = irep;
      end else if (iss) begin
        m_drop = 1;
      end else if (m_valid && ev_ready) begin
        m_valid = 0;
      end
      if (drop_clr && !(iss && m_valid && !ev_ready && m_drop)) begin
        if (!(iss && !(m_valid && !ev_ready) == 0)) m_drop = 0;
      end
    end
  end

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("m_valid", ev_valid, m_valid);
      check("m_id", ev_id, m_id);
      check("m_repeat", ev_repeat, m_rep);
      check("m_drop", ev_drop, m_drop);
    end
  end

  int ev_at[$];
  int n;

  initial begin
    rst = 1; db_in = 4'b0010; ev_ready = 0; drop_clr = 0;
    ticks(2);
    check("rst_valid", ev_valid, 0);
    check("rst_id", ev_id, 0);
    check("rst_repeat", ev_repeat, 0);
    check("rst_drop", ev_drop, 0);
    check("rst_state", dbg_state, 0);

    // button held through reset, then released and re-pressed
    rst = 0;
    ticks(3);
    check("t1_held_no_ev", ev_valid, 0);
    db_in = 4'b0000; ticks(3);
    db_in = 4'b0010; tick();
    check("t1_valid", ev_valid, 1);
    check("t1_id", ev_id, 1);
    check("t1_repeat", ev_repeat, 0);
    ev_ready = 1; tick();
    check("t1_accepted", ev_valid, 0);
    db_in = 4'b0000; ticks(3);

    // simultaneous rise: low index wins, button 3 ignored
    db_in = 4'b1010; tick();
    check("t2_valid", ev_valid, 1);
    check("t2_id", ev_id, 1);
    ticks(4);
    db_in = 4'b1000; n = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (ev_valid) n++; end
    check("t2_b3_ignored", n, 0);
    db_in = 4'b0000; ticks(2);
    db_in = 4'b1000; tick();
    check("t2_b3_valid", ev_valid, 1);
    check("t2_b3_id", ev_id, 3);
    db_in = 4'b0000; ticks(3);

    // 40-cycle hold with consumer always ready
    ev_ready = 1; db_in = 4'b0001;
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (ev_valid) ev_at.push_back(k);
      if (k == 17) check("t3_rep_at17", ev_repeat, 1);
      if (k == 40) db_in = 4'b0000;
    end
    check("t3_count", ev_at.size(), 4);
    if (ev_at.size() == 4) begin
      check("t3_ev0", ev_at[0], 1);
      check("t3_ev1", ev_at[1], 17);
      check("t3_ev2", ev_at[2], 25);
      check("t3_ev3", ev_at[3], 33);
    end
    ticks(2);

    // same hold, consumer stalled: repeats are discarded
    ev_ready = 0; db_in = 4'b0001;
    for (int k = 1; k <= 41; k++) begin
      tick();
      case (k)
        17: check("t4_drop17", ev_drop, 1);
        20: check("t4_drop20", ev_drop, 1);
        21: check("t4_clr21", ev_drop, 0);
        24: check("t4_drop24", ev_drop, 0);
        25: check("t4_drop25", ev_drop, 1);
        29: check("t4_clr29", ev_drop, 0);
        33: check("t4_set_wins", ev_drop, 1);
        40: begin
          check("t4_valid", ev_valid, 1);
          check("t4_id", ev_id, 0);
          check("t4_repeat", ev_repeat, 0);
        end
        default: ;
      endcase
      drop_clr = (k == 20 || k == 28 || k == 32);
      if (k == 40) db_in = 4'b0000;
    end
    drop_clr = 1; ev_ready = 1; tick();
    drop_clr = 0; ticks(2);

    // release in REPEAT with a new rise in the same cycle
    db_in = 4'b0100;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 24) db_in = 4'b0001;
    end
    check("t5_valid", ev_valid, 1);
    check("t5_id", ev_id, 0);
    check("t5_repeat", ev_repeat, 0);
    db_in = 4'b0000; ticks(3);

    // reset while in REPEAT with a pending event
    ev_ready = 0; db_in = 4'b0010;
    ticks(20);
    check("t6_state_rep", dbg_state, 2);
    check("t6_pending", ev_valid, 1);
    check("t6_drop_pre", ev_drop, 1);
    rst = 1; tick();
    check("t6_valid", ev_valid, 0);
    check("t6_drop", ev_drop, 0);
    check("t6_state", dbg_state, 0);
    rst = 0; n = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (ev_valid) n++; end
    check("t6_held_quiet", n, 0);
    db_in = 4'b0000; ticks(2);
    db_in = 4'b0010; tick();
    check("t6_repress_valid", ev_valid, 1);
    check("t6_repress_id", ev_id, 1);
    check("t6_repress_rep", ev_repeat, 0);
    db_in = 4'b0000; ev_ready = 1; ticks(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Sequences N debounced push-button levels into a single stream of button events with a valid/ready handshake.
- Emits one event per press, then auto-repeat events while the button stays held.
- Sits between the per-button debouncer outputs and the consumer that updates the 8-bit value / ASCII display logic.
- Arbitrates simultaneous presses with fixed low-index priority and one-owner-at-a-time semantics.

Parameters:
- N_BTN, 4, number of button inputs (≥2).
- HOLD_CYC, 16, cycles a button must be held after the initial event before the first repeat (≥2).
- REP_CYC, 8, cycles between successive repeat events (≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- db_in  input  N_BTN  debounced button levels, 1 = pressed, synchronous to clk.
- ev_ready  input  1  consumer accepts the event when ev_valid & ev_ready.
- drop_clr  input  1  single-cycle pulse that clears ev_drop.
- ev_valid  output  1  event holding register occupied.
- ev_id  output  $clog2(N_BTN)  index of the button for the held event.
- ev_repeat  output  1  0 = initial press event, 1 = auto-repeat event.
- ev_drop  output  1  sticky flag: an event was discarded because the holding register was full.

Behaviour:
- Reset: state=IDLE, cnt=0, owner=0, ev_valid=0, ev_id=0, ev_repeat=0, ev_drop=0. The previous-level register db_q loads db_in during reset, so a button held through reset does not generate an event.
- Edge detect: rise = db_in & ~db_q; db_q <= db_in every non-reset cycle.
- Counter: cnt has width $clog2(max(HOLD_CYC,REP_CYC)). It is zeroed on every state entry and every issue.
- FSM states are IDLE, HOLD and REPEAT.
  - IDLE: if rise≠0, owner = lowest set index of rise; issue event (repeat=0); go to HOLD. Otherwise stay.
  - HOLD: if db_in[owner]=0, apply the release rule. Else if cnt=HOLD_CYC-1, issue event (repeat=1) and go to REPEAT. Else cnt++.
  - REPEAT: if db_in[owner]=0, apply the release rule. Else if cnt=REP_CYC-1, issue event (repeat=1) and stay. Else cnt++.
  - Release rule: in the release cycle, evaluate exactly as IDLE using that cycle's rise, so a new owner can be taken with no gap. Otherwise go to IDLE. Release has priority over a due repeat in the same cycle.
- Rises on non-owner buttons while the owner is held are ignored, not queued.
- Issue / holding register:
  - If ev_valid=0 or ev_ready=1, load ev_id/ev_repeat and set ev_valid=1.
  - Otherwise discard the new event, leave the register unchanged and set ev_drop=1.
  - Without an issue, ev_valid clears on ev_valid & ev_ready.
- Latency: a rise at cycle t produces ev_valid=1 at t+1. ev_id and ev_repeat are stable while ev_valid=1 and ev_ready=0.
- Repeat timing: with the initial event visible at t+1, repeats are visible at t+1+HOLD_CYC, then every REP_CYC cycles.
- ev_drop: set by a discard, cleared by drop_clr. If both occur in the same cycle, set wins. Cleared only by rst or drop_clr.
- rst mid-operation (any state, pending event) returns everything to reset values in the next cycle; the pending event is lost.

Test Plan:
- Defaults, db_in=0010 held across rst, then released and re-pressed at t → no event before the re-press; ev_valid=1, ev_id=1, ev_repeat=0 at t+1; ev_valid=0 the cycle after acceptance (ev_ready=1).
- db_in 0000→1010 in one cycle, button 3 held throughout → exactly one initial event, ev_id=1; no event for button 3 until button 1 is released and button 3 rises again.
- Button 0 pressed at t, held 40 cycles, released at t+40, ev_ready=1 → events visible at t+1 (repeat=0), t+17, t+25, t+33 (repeat=1); nothing at t+41.
- Same hold with ev_ready=0 → holding register keeps ev_id=0, ev_repeat=0; ev_drop=1 from t+17. A drop_clr pulse at t+20 clears it; it is set again at t+25. drop_clr coincident with a discard leaves ev_drop=1.
- Button 2 in REPEAT; in one cycle db_in[2] falls and db_in[0] rises → next-cycle event ev_id=0, ev_repeat=0; button 2's due repeat is not issued.
- rst asserted for one cycle in REPEAT with ev_valid=1 → next cycle ev_valid=0, ev_drop=0, state IDLE; held button produces no event until released and re-pressed.
